// File: rtl/fiber_pkg.sv
// Shared definitions for the fiberBank PE-side arbiter: request encodings, FSM states and
// a one-hot check used when classifying incoming requests.
package fiber_pkg;

    localparam logic [3:0] FETCH_REQ   = 4'b0001;
    localparam logic [3:0] READ_REQ    = 4'b0010;
    localparam logic [3:0] WRITE_REQ   = 4'b0100;
    localparam logic [3:0] CONSUME_REQ = 4'b1000;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWdata,
        StRdata
    } arb_state_e;

    function automatic logic is_onehot4(input logic [3:0] t);
        return (t != 4'b0000) && ((t & (t - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/fiber_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i, wrapping
// from NumPe-1 back to 0.
module fiber_rr_arbiter #(
    parameter int unsigned NumPe = 4,
    parameter int unsigned IdxW  = $clog2(NumPe)
) (
    input  logic [NumPe-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [NumPe-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             any_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned off = 0; off < NumPe; off++) begin
            cand = IdxW'((32'(ptr_i) + off) % NumPe);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/fiber_bank_arbiter.sv
// Round-robin sharing of one fiberBank PE-side port among NUM_PE requesters, one transaction
// at a time. Optional statistics counters are built when FIBER_ARB_STATS_EN is defined.
module fiber_bank_arbiter
    import fiber_pkg::*;
#(
    parameter int unsigned NUM_PE     = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 64
`ifdef FIBER_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W      = 16
`endif
) (
    input  logic                           i_clk,
    input  logic                           i_nreset,
    input  logic [NUM_PE*4-1:0]            i_pe_type,
    input  logic [NUM_PE*ADDR_WIDTH-1:0]   i_pe_addr,
    input  logic [NUM_PE-1:0]              i_pe_type_valid,
    output logic [NUM_PE-1:0]              o_pe_type_ready,
    input  logic [NUM_PE*DATA_WIDTH-1:0]   i_pe_data,
    input  logic [NUM_PE-1:0]              i_pe_data_valid,
    output logic [NUM_PE-1:0]              o_pe_data_ready,
    output logic [DATA_WIDTH-1:0]          o_pe_rdata,
    output logic [NUM_PE-1:0]              o_pe_rdata_valid,
    input  logic [NUM_PE-1:0]              i_pe_rdata_ready,
    output logic [3:0]                     o_bank_type,
    output logic [ADDR_WIDTH-1:0]          o_bank_addr,
    output logic                           o_bank_type_valid,
    input  logic                           i_bank_type_ready,
    output logic [DATA_WIDTH-1:0]          o_bank_data,
    output logic                           o_bank_data_valid,
    input  logic                           i_bank_data_ready,
    input  logic [DATA_WIDTH-1:0]          i_bank_rdata,
    input  logic                           i_bank_rdata_valid,
    output logic                           o_bank_rdata_ready,
`ifdef FIBER_ARB_STATS_EN
    input  logic                           i_stats_clr,
    output logic [NUM_PE*CNT_W-1:0]        o_grant_cnt,
    output logic [CNT_W-1:0]               o_wait_cnt,
`endif
    output logic [$clog2(NUM_PE)-1:0]      o_grant_id,
    output logic                           o_busy,
    output logic                           o_bad_type
);

    localparam int unsigned IdxW = $clog2(NUM_PE);

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        return (32'(idx) == NUM_PE - 1) ? '0 : idx + 1'b1;
    endfunction

    arb_state_e            state_q, state_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic [3:0]            type_q, type_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  bad_q, bad_d;

    logic [NUM_PE-1:0]     win_gnt;
    logic [IdxW-1:0]       win_idx;
    logic                  win_any;
    logic                  accept;
    logic [3:0]            win_type;

    fiber_rr_arbiter #(
        .NumPe (NUM_PE),
        .IdxW  (IdxW)
    ) u_rr (
        .req_i (i_pe_type_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    assign accept   = (state_q == StIdle) && win_any;
    assign win_type = i_pe_type[win_idx*4 +: 4];

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept && is_onehot4(win_type)) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (i_bank_type_ready) begin
                    case (type_q)
                        WRITE_REQ:             state_d = StWdata;
                        READ_REQ, CONSUME_REQ: state_d = StRdata;
                        FETCH_REQ:             state_d = StIdle;
                        default:               state_d = StIdle;
                    endcase
                end
            end
            StWdata: begin
                if (i_bank_data_ready && i_pe_data_valid[grant_q]) begin
                    state_d = StIdle;
                end
            end
            StRdata: begin
                if (i_bank_rdata_valid && i_pe_rdata_ready[grant_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Request capture and round-robin pointer; a dropped request still advances the pointer.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        type_d   = type_q;
        addr_d   = addr_q;
        bad_d    = 1'b0;
        if (accept) begin
            grant_d = win_idx;
            type_d  = win_type;
            addr_d  = i_pe_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            if (!is_onehot4(win_type)) begin
                bad_d    = 1'b1;
                rr_ptr_d = next_idx(win_idx);
            end
        end
        if ((state_q != StIdle) && (state_d == StIdle)) begin
            rr_ptr_d = next_idx(grant_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
            type_q   <= '0;
            addr_q   <= '0;
            bad_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            bad_q    <= bad_d;
        end
    end

    always_comb begin
        o_pe_type_ready    = '0;
        o_pe_data_ready    = '0;
        o_pe_rdata_valid   = '0;
        o_pe_rdata         = i_bank_rdata;
        o_bank_type        = type_q;
        o_bank_addr        = addr_q;
        o_bank_type_valid  = 1'b0;
        o_bank_data        = i_pe_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        o_bank_data_valid  = 1'b0;
        o_bank_rdata_ready = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_any) begin
                    o_pe_type_ready = win_gnt;
                end
            end
            StIssue: o_bank_type_valid = 1'b1;
            StWdata: begin
                o_bank_data_valid        = i_pe_data_valid[grant_q];
                o_pe_data_ready[grant_q] = i_bank_data_ready;
            end
            StRdata: begin
                o_pe_rdata_valid[grant_q] = i_bank_rdata_valid;
                o_bank_rdata_ready        = i_pe_rdata_ready[grant_q];
            end
            default: ;
        endcase
    end

    assign o_grant_id = grant_q;
    assign o_busy     = (state_q != StIdle);
    assign o_bad_type = bad_q;

`ifdef FIBER_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt_q [NUM_PE];
    logic [CNT_W-1:0] grant_cnt_d [NUM_PE];
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             waiting;

    assign waiting = |(i_pe_type_valid & ~o_pe_type_ready);

    // Saturating counters; clear takes priority over any increment in the same cycle.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PE; p++) begin
            grant_cnt_d[p] = grant_cnt_q[p];
            if (i_stats_clr) begin
                grant_cnt_d[p] = '0;
            end else if (o_pe_type_ready[p] && !(&grant_cnt_q[p])) begin
                grant_cnt_d[p] = grant_cnt_q[p] + 1'b1;
            end
        end
        wait_cnt_d = wait_cnt_q;
        if (i_stats_clr) begin
            wait_cnt_d = '0;
        end else if (waiting && !(&wait_cnt_q)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            for (int unsigned p = 0; p < NUM_PE; p++) begin
                grant_cnt_q[p] <= '0;
            end
            wait_cnt_q <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PE; p++) begin
                grant_cnt_q[p] <= grant_cnt_d[p];
            end
            wait_cnt_q <= wait_cnt_d;
        end
    end

    for (genvar p = 0; p < NUM_PE; p++) begin : g_cnt_out
        assign o_grant_cnt[p*CNT_W +: CNT_W] = grant_cnt_q[p];
    end
    assign o_wait_cnt = wait_cnt_q;
`endif

endmodule
